megapacket_splitter: RTL and testbench
======================================

# megapacket_splitter

Splits an AXI-Stream megapacket (one long burst closed by a single `tlast`) back into fixed-length sub-packets by asserting `tlast` every `beats_per_packet` accepted beats. It sits on the receive side of the DMA path, ahead of consumers that expect per-record framing. It is the inverse of the megapacket builder on the capture path. Beats pass through a registered output stage with a skid buffer, so back-pressure is honoured at full throughput.

## Interface
- `DATA_W`, default 32: stream data width.
- `LEN_W`, default 16: width of `beats_per_packet` and of the beat counter.
- `aclk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `beats_per_packet`  in  LEN_W  sub-packet length in beats. It is sampled at the first beat of each megapacket.
- `S_AXIS_IN_tdata`  in  DATA_W  input data.
- `S_AXIS_IN_tvalid`  in  1  input valid.
- `S_AXIS_IN_tlast`  in  1  end of megapacket.
- `S_AXIS_IN_tready`  out  1  input ready.
- `M_AXIS_OUT_tdata`  out  DATA_W  output data.
- `M_AXIS_OUT_tvalid`  out  1  output valid.
- `M_AXIS_OUT_tlast`  out  1  end of sub-packet.
- `M_AXIS_OUT_tready`  in  1  output ready.
- `subpacket_count`  out  32  number of sub-packets emitted; wraps modulo 2^32.
- `megapacket_count`  out  32  number of input `tlast` beats accepted; wraps modulo 2^32.
- `short_err`  out  1  sticky flag; cleared only by `rst`.

## Operation
- Input handshake: a beat is accepted when `S_AXIS_IN_tvalid && S_AXIS_IN_tready`. Output handshake: a beat is delivered when `M_AXIS_OUT_tvalid && M_AXIS_OUT_tready`.
- State flag `first`:
  - Set by reset and by every accepted input `tlast`.
  - On an accepted beat with `first=1`, `bpp_reg` is loaded from `beats_per_packet`; a value of 0 is loaded as 1. `first` then clears.
  - The loaded value is used for that same beat.
- Beat counter `beat_cnt` (LEN_W bits):
  - Counts accepted beats, range 0 .. bpp−1. The effective length bpp is `bpp_reg`, or the freshly loaded value on a `first` beat.
  - Output tlast for an accepted beat = `(beat_cnt == bpp−1) || S_AXIS_IN_tlast`.
  - After a beat with output tlast, `beat_cnt` returns to 0; otherwise it increments.
- An input `tlast` with `beat_cnt != bpp−1` produces a short final sub-packet:
  - The beat is forwarded with tlast = 1.
  - `short_err` is set to 1 in the same cycle the beat is accepted.
- The counters increment on the input-acceptance cycle:
  - `subpacket_count` increments by 1 for each accepted beat that carries output tlast.
  - `megapacket_count` increments by 1 for each accepted input `tlast`.
  - When both events occur in one cycle, each counter increments by exactly 1.
- Data is passed through unmodified. Beats are never dropped, duplicated or reordered.
- Storage is two entries: the output register `out_*` and the skid register `skid_*`. Each entry holds {data, tlast, valid}.

## Timing
- Reset values:
  - `M_AXIS_OUT_tvalid=0`, `M_AXIS_OUT_tlast=0`, `M_AXIS_OUT_tdata=0`.
  - `S_AXIS_IN_tready=0` while `rst` is high, then 1 on the first cycle after `rst` is deasserted.
  - Both counters = 0, `short_err=0`, `beat_cnt=0`, `first=1`, skid entry empty.
- Latency: a beat accepted in cycle N is presented on M in cycle N+1 when the output register is empty or drained in cycle N.
- Throughput: 1 beat per cycle while `M_AXIS_OUT_tready` stays high.
- `S_AXIS_IN_tready` is registered and equals `!skid_valid`. It never depends combinationally on `M_AXIS_OUT_tready`.
- When `M_AXIS_OUT_tready` is low and the output register is full, one further beat may be accepted into skid. Ready drops in the next cycle.
- When the output register drains, skid moves into it, and ready returns high the following cycle.
- Output valid, data and tlast stay stable while `M_AXIS_OUT_tvalid=1` and `M_AXIS_OUT_tready=0`.
- Reset mid-operation: all in-flight beats are discarded and state returns to the reset values in the cycle after `rst` is sampled high. A partially emitted sub-packet is not closed.
- A change to `beats_per_packet` in mid-megapacket has no effect until the next megapacket's first beat.

## Structure
- The shared package holds `DATA_W` and `LEN_W` defaults and the counter width (32).
- Sub-module `axis_skid_buffer` (parameterised by payload width) holds the two-entry output and skid storage and its ready logic. The payload is {tdata, tlast}.
- The top level holds the `first` flag, `bpp_reg`, `beat_cnt`, tlast generation, the counters and `short_err`.

## Test plan
- bpp=4; 12-beat megapacket (data 0..11); M ready always high → output tlast on data 3, 7, 11; `subpacket_count=3`; `megapacket_count=1`; `short_err=0`; 1-cycle latency.
- bpp=4; 10-beat megapacket → tlast on data 3, 7, 9; `short_err=1`; `subpacket_count=3`.
- bpp=0; 3-beat megapacket → tlast on every beat; `subpacket_count=3`.
- bpp=5; 20 beats with M ready toggling on a random 50% pattern → output sequence identical to input; `S_AXIS_IN_tready` low for at most the cycles while skid is full; no beat lost; tdata stable while stalled.
- `beats_per_packet` changed from 4 to 2 at beat 5 of a 12-beat megapacket → that megapacket still framed at 4; the next 4-beat megapacket is framed at 2 (tlast on beats 1 and 3).
- `rst` pulsed with beats held in the output and skid registers → cycle after reset: `M_AXIS_OUT_tvalid=0`, counters 0, `short_err=0`; the next beat reloads bpp.

Source files
------------

// File: rtl/megapacket_splitter_pkg.sv
// Shared defaults for the megapacket splitter: stream/length widths and the
// width of the statistics counters.
package megapacket_splitter_pkg;
    localparam int DATA_W_DEFAULT = 32;
    localparam int LEN_W_DEFAULT  = 16;
    localparam int CNT_W          = 32;
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: an output register plus one skid entry,
// with a registered ready so upstream never sees downstream ready combinationally.
module axis_skid_buffer #(
    parameter int PAYLOAD_W = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [PAYLOAD_W-1:0] out_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 out_v;
    logic                 skid_v;
    logic                 ready_q;
    logic                 accept;
    logic                 out_open;

    assign accept      = in_valid && ready_q;
    assign out_open    = out_ready || !out_v;
    assign in_ready    = ready_q;
    assign out_payload = out_q;
    assign out_valid   = out_v;

    // ready_q always mirrors !skid_v of the next cycle, so a beat can only
    // arrive while the skid entry is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v   <= 1'b0;
            out_q   <= '0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
        end else if (out_open) begin
            ready_q <= 1'b1;
            skid_v  <= 1'b0;
            if (skid_v) begin
                out_q <= skid_q;
                out_v <= 1'b1;
            end else if (accept) begin
                out_q <= in_payload;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q  <= in_payload;
            skid_v  <= 1'b1;
            ready_q <= 1'b0;
        end
    end

endmodule

// File: rtl/megapacket_splitter.sv
// Re-frames one long AXI-Stream megapacket into fixed-length sub-packets,
// closing a short final sub-packet early when the megapacket ends.
module megapacket_splitter
    import megapacket_splitter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  beats_per_packet,
    input  logic [DATA_W-1:0] S_AXIS_IN_tdata,
    input  logic              S_AXIS_IN_tvalid,
    input  logic              S_AXIS_IN_tlast,
    output logic              S_AXIS_IN_tready,
    output logic [DATA_W-1:0] M_AXIS_OUT_tdata,
    output logic              M_AXIS_OUT_tvalid,
    output logic              M_AXIS_OUT_tlast,
    input  logic              M_AXIS_OUT_tready,
    output logic [CNT_W-1:0]  subpacket_count,
    output logic [CNT_W-1:0]  megapacket_count,
    output logic              short_err
);

    logic             first;
    logic [LEN_W-1:0] bpp_reg;
    logic [LEN_W-1:0] bpp_new;
    logic [LEN_W-1:0] bpp_eff;
    logic [LEN_W-1:0] beat_cnt;
    logic             sub_last;
    logic             out_last;
    logic             accept;
    logic [CNT_W-1:0] sub_cnt;
    logic [CNT_W-1:0] mp_cnt;
    logic             short_q;

    assign accept           = S_AXIS_IN_tvalid && S_AXIS_IN_tready;
    assign subpacket_count  = sub_cnt;
    assign megapacket_count = mp_cnt;
    assign short_err        = short_q;

    // On the first beat the freshly sampled length governs that same beat.
    always_comb begin
        bpp_new  = (beats_per_packet == '0) ? LEN_W'(1) : beats_per_packet;
        bpp_eff  = first ? bpp_new : bpp_reg;
        sub_last = (beat_cnt == bpp_eff - LEN_W'(1));
        out_last = sub_last || S_AXIS_IN_tlast;
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            first    <= 1'b1;
            bpp_reg  <= LEN_W'(1);
            beat_cnt <= '0;
            sub_cnt  <= '0;
            mp_cnt   <= '0;
            short_q  <= 1'b0;
        end else if (accept) begin
            if (first) bpp_reg <= bpp_new;
            first    <= S_AXIS_IN_tlast;
            beat_cnt <= out_last ? '0 : beat_cnt + LEN_W'(1);
            if (out_last) sub_cnt <= sub_cnt + CNT_W'(1);
            if (S_AXIS_IN_tlast) begin
                mp_cnt <= mp_cnt + CNT_W'(1);
                if (!sub_last) short_q <= 1'b1;
            end
        end
    end

    axis_skid_buffer #(
        .PAYLOAD_W(DATA_W + 1)
    ) u_skid (
        .clk        (aclk),
        .rst        (rst),
        .in_payload ({S_AXIS_IN_tdata, out_last}),
        .in_valid   (S_AXIS_IN_tvalid),
        .in_ready   (S_AXIS_IN_tready),
        .out_payload({M_AXIS_OUT_tdata, M_AXIS_OUT_tlast}),
        .out_valid  (M_AXIS_OUT_tvalid),
        .out_ready  (M_AXIS_OUT_tready)
    );

endmodule

// File: tb/tb_megapacket_splitter.sv
// Randomized bench for megapacket_splitter: expected framing is derived per
// megapacket from its length and sub-packet size, then matched at the output.
module tb_megapacket_splitter;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic              aclk = 1'b0;
    logic              rst;
    logic [LEN_W-1:0]  beats_per_packet;
    logic [DATA_W-1:0] S_AXIS_IN_tdata;
    logic              S_AXIS_IN_tvalid;
    logic              S_AXIS_IN_tlast;
    logic              S_AXIS_IN_tready;
    logic [DATA_W-1:0] M_AXIS_OUT_tdata;
    logic              M_AXIS_OUT_tvalid;
    logic              M_AXIS_OUT_tlast;
    logic              M_AXIS_OUT_tready;
    logic [31:0]       subpacket_count;
    logic [31:0]       megapacket_count;
    logic              short_err;

    megapacket_splitter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .aclk             (aclk),
        .rst              (rst),
        .beats_per_packet (beats_per_packet),
        .S_AXIS_IN_tdata  (S_AXIS_IN_tdata),
        .S_AXIS_IN_tvalid (S_AXIS_IN_tvalid),
        .S_AXIS_IN_tlast  (S_AXIS_IN_tlast),
        .S_AXIS_IN_tready (S_AXIS_IN_tready),
        .M_AXIS_OUT_tdata (M_AXIS_OUT_tdata),
        .M_AXIS_OUT_tvalid(M_AXIS_OUT_tvalid),
        .M_AXIS_OUT_tlast (M_AXIS_OUT_tlast),
        .M_AXIS_OUT_tready(M_AXIS_OUT_tready),
        .subpacket_count  (subpacket_count),
        .megapacket_count (megapacket_count),
        .short_err        (short_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    beat_t       exp_q[$];
    int          acc_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          inflight = 0;
    int          mode   = 0;   // 0: M ready high, 1: random, 2: held low
    bit          gaps   = 0;
    bit          live   = 0;
    bit          stalled_prev = 0;
    logic [DATA_W-1:0] prev_d;
    logic              prev_l;
    longint      exp_sp = 0;
    longint      exp_mp = 0;
    bit          exp_short = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge aclk) begin
        #1;
        case (mode)
            0:       M_AXIS_OUT_tready = 1'b1;
            1:       M_AXIS_OUT_tready = 1'($urandom_range(0, 1));
            default: M_AXIS_OUT_tready = 1'b0;
        endcase
    end

    // Monitor: values seen at the falling edge are what the next rising edge consumes.
    always @(negedge aclk) begin
        bit    in_hs;
        bit    out_hs;
        beat_t e;
        int    a;
        cyc++;
        if (rst) begin
            inflight     = 0;
            acc_q.delete();
            live         = 0;
            stalled_prev = 0;
        end else begin
            if (live) chk_val("tready", 64'(S_AXIS_IN_tready), 64'(inflight < 2));
            if (live && stalled_prev) begin
                chk_val("stall_valid", 64'(M_AXIS_OUT_tvalid), 64'd1);
                chk_val("stall_data", 64'(M_AXIS_OUT_tdata), 64'(prev_d));
                chk_val("stall_last", 64'(M_AXIS_OUT_tlast), 64'(prev_l));
            end
            in_hs  = S_AXIS_IN_tvalid && S_AXIS_IN_tready;
            out_hs = M_AXIS_OUT_tvalid && M_AXIS_OUT_tready;
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    chk_val("extra_beat", 64'(M_AXIS_OUT_tdata), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk_val("tdata", 64'(M_AXIS_OUT_tdata), 64'(e.d));
                    chk_val("tlast", 64'(M_AXIS_OUT_tlast), 64'(e.l));
                end
                if (acc_q.size() != 0) begin
                    a = acc_q.pop_front();
                    if (mode == 0) chk_val("latency", 64'(cyc - a), 64'd1);
                end
            end
            if (in_hs) acc_q.push_back(cyc);
            inflight     = inflight + int'(in_hs) - int'(out_hs);
            stalled_prev = M_AXIS_OUT_tvalid && !M_AXIS_OUT_tready;
            prev_d       = M_AXIS_OUT_tdata;
            prev_l       = M_AXIS_OUT_tlast;
            live         = 1;
        end
    end

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
        bit hs;
        bit ok;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(posedge aclk);
            #1;
        end
        S_AXIS_IN_tdata  = d;
        S_AXIS_IN_tlast  = l;
        S_AXIS_IN_tvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            hs = S_AXIS_IN_tvalid && S_AXIS_IN_tready;
            @(posedge aclk);
            #1;
            if (hs) begin
                ok = 1;
                break;
            end
        end
        S_AXIS_IN_tvalid = 1'b0;
        S_AXIS_IN_tlast  = 1'b0;
        if (!ok) chk_val("in_handshake_timeout", 64'd0, 64'd1);
    endtask

    // Expected framing: tlast every b beats plus on the final beat, b = max(bpp,1).
    task automatic send_mp(input int len, input int bpp, input int chg_at,
                           input int new_bpp, input bit rnd_data);
        int                b;
        logic [DATA_W-1:0] d[$];
        beat_t             e;
        b = (bpp == 0) ? 1 : bpp;
        beats_per_packet = LEN_W'(bpp);
        for (int i = 0; i < len; i++) begin
            e.d = rnd_data ? DATA_W'($urandom) : DATA_W'(i);
            e.l = ((i % b) == b - 1) || (i == len - 1);
            d.push_back(e.d);
            exp_q.push_back(e);
        end
        exp_sp += (len + b - 1) / b;
        exp_mp += 1;
        if ((len % b) != 0) exp_short = 1;
        for (int i = 0; i < len; i++) begin
            if (i == chg_at) beats_per_packet = LEN_W'(new_bpp);
            send_beat(d[i], i == len - 1);
        end
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 1000 && (inflight != 0 || exp_q.size() != 0); i++) @(posedge aclk);
        #1;
        chk_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk_val({tag, "_subpacket_count"}, 64'(subpacket_count), 64'(exp_sp));
        chk_val({tag, "_megapacket_count"}, 64'(megapacket_count), 64'(exp_mp));
        chk_val({tag, "_short_err"}, 64'(short_err), 64'(exp_short));
    endtask

    initial begin
        rst              = 1'b1;
        beats_per_packet = '0;
        S_AXIS_IN_tdata  = '0;
        S_AXIS_IN_tvalid = 1'b0;
        S_AXIS_IN_tlast  = 1'b0;
        M_AXIS_OUT_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk_val("rst_tvalid", 64'(M_AXIS_OUT_tvalid), 64'd0);
        chk_val("rst_tlast", 64'(M_AXIS_OUT_tlast), 64'd0);
        chk_val("rst_tdata", 64'(M_AXIS_OUT_tdata), 64'd0);
        chk_val("rst_tready", 64'(S_AXIS_IN_tready), 64'd0);
        chk_val("rst_subpacket_count", 64'(subpacket_count), 64'd0);
        chk_val("rst_megapacket_count", 64'(megapacket_count), 64'd0);
        chk_val("rst_short_err", 64'(short_err), 64'd0);
        rst = 1'b0;
        @(posedge aclk);
        #1;
        chk_val("tready_after_rst", 64'(S_AXIS_IN_tready), 64'd1);

        mode = 0; gaps = 0;
        send_mp(12, 4, -1, 0, 0);
        drain_and_check("bpp4_len12");
        send_mp(10, 4, -1, 0, 0);
        drain_and_check("bpp4_len10");
        send_mp(3, 0, -1, 0, 0);
        drain_and_check("bpp0_len3");

        mode = 1; gaps = 1;
        send_mp(20, 5, -1, 0, 1);
        drain_and_check("bpp5_random_ready");

        mode = 0; gaps = 0;
        send_mp(12, 4, 5, 2, 0);
        send_mp(4, 2, -1, 0, 0);
        drain_and_check("bpp_change");

        mode = 1; gaps = 1;
        for (int k = 0; k < 6; k++) send_mp($urandom_range(1, 9), $urandom_range(0, 4), -1, 0, 1);
        drain_and_check("random_mps");

        // Park one beat in the output register and one in skid, then reset.
        mode = 2; gaps = 0;
        repeat (2) @(posedge aclk);
        #1;
        beats_per_packet = LEN_W'(5);
        send_beat(DATA_W'(32'hA5A5_0001), 1'b0);
        send_beat(DATA_W'(32'hA5A5_0002), 1'b0);
        @(posedge aclk);
        #1;
        chk_val("skid_full_tready", 64'(S_AXIS_IN_tready), 64'd0);
        rst = 1'b1;
        @(posedge aclk);
        #1;
        chk_val("midrst_tvalid", 64'(M_AXIS_OUT_tvalid), 64'd0);
        chk_val("midrst_subpacket_count", 64'(subpacket_count), 64'd0);
        chk_val("midrst_megapacket_count", 64'(megapacket_count), 64'd0);
        chk_val("midrst_short_err", 64'(short_err), 64'd0);
        chk_val("midrst_tready", 64'(S_AXIS_IN_tready), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_sp = 0; exp_mp = 0; exp_short = 0;
        mode = 0;
        @(posedge aclk);
        #1;
        send_mp(4, 2, -1, 0, 0);
        drain_and_check("after_midrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
